musa_alu_mc: RTL

Multi-cycle, parametrised successor to the EX-stage ALU of the MUSA core. Single-cycle ops (add, sub, and, or, not, cmp) produce a registered result one cycle after acceptance. Full-width unsigned multiply (shift-add) and divide (restoring) run iteratively over WIDTH cycles. Operands enter and results leave over valid/ready handshakes, so the EX stage can stall on long ops.

---
 rtl/musa_alu_pkg.sv | 23 ++
 rtl/musa_alu_iter.sv | 78 +++++++
 rtl/musa_alu_mc.sv | 134 +++++++++++++
 3 files changed

// File: rtl/musa_alu_pkg.sv
// Shared op codes, flag encodings and FSM state type for the MUSA multi-cycle ALU.
package musa_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_MUL = 4'd6;
    localparam logic [3:0] OP_DIV = 4'd7;

    localparam logic [2:0] FLAG_NONE  = 3'b000;
    localparam logic [2:0] FLAG_EQ    = 3'b001;
    localparam logic [2:0] FLAG_EXC   = 3'b010;
    localparam logic [2:0] FLAG_OVF   = 3'b011;
    localparam logic [2:0] FLAG_UNF   = 3'b100;
    localparam logic [2:0] FLAG_ABOVE = 3'b101;
    localparam logic [2:0] FLAG_BELOW = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

endpackage

// File: rtl/musa_alu_iter.sv
// Shared iterative datapath: shift-add unsigned multiply and restoring divide.
// lo/hi present the values after the step taken on the coming edge, valid with done.
module musa_alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    count;
    logic             div_mode;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // The restored remainder is always below the divisor, so WIDTH bits hold it between steps.
    always_comb begin
        sum      = {1'b0, acc} + (quo[0] ? {1'b0, divisor} : '0);
        shifted  = {acc, quo[WIDTH-1]};
        diff     = shifted - {1'b0, divisor};
        acc_next = sum[WIDTH:1];
        quo_next = {sum[0], quo[WIDTH-1:1]};
        if (div_mode) begin
            if (diff[WIDTH]) begin
                acc_next = shifted[WIDTH-1:0];
                quo_next = {quo[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = diff[WIDTH-1:0];
                quo_next = {quo[WIDTH-2:0], 1'b1};
            end
        end
    end

    assign lo   = quo_next;
    assign hi   = acc_next;
    assign done = busy && (count == LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            busy     <= 1'b0;
            count    <= '0;
            div_mode <= 1'b0;
            acc      <= '0;
            quo      <= '0;
            divisor  <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            count    <= '0;
            div_mode <= is_div;
            acc      <= '0;
            quo      <= op_a;
            divisor  <= op_b;
        end else if (busy) begin
            acc   <= acc_next;
            quo   <= quo_next;
            count <= count + 1'b1;
            if (count == LAST)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/musa_alu_mc.sv
// Multi-cycle MUSA EX-stage ALU: handshake FSM, single-cycle ops, iterative mul/div.
// state | meaning
// IDLE  | ready, in_ready high
// MUL   | shift-add multiply iterating
// DIV   | restoring divide iterating
// DONE  | result valid, waiting for out_ready
module musa_alu_mc
    import musa_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [2:0]       flag
);

    state_t           state;
    logic             accept;
    logic             start_iter;
    logic             iter_busy;
    logic             iter_done;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] sum_ab;
    logic [WIDTH-1:0] dif_ab;
    logic [WIDTH-1:0] simple_res;
    logic [WIDTH-1:0] simple_hi;
    logic [2:0]       simple_flag;

    assign in_ready   = (state == S_IDLE) && reset;
    assign out_valid  = (state == S_DONE);
    assign accept     = in_valid && in_ready;
    assign start_iter = accept && ((op == OP_MUL) || (op == OP_DIV && data_b != '0));
    assign sum_ab     = data_a + data_b;
    assign dif_ab     = data_a - data_b;

    // Signed overflow direction follows the sign of operand A.
    always_comb begin
        simple_res  = '0;
        simple_hi   = '0;
        simple_flag = FLAG_NONE;
        case (op)
            OP_ADD: begin
                simple_res = sum_ab;
                if (data_a[WIDTH-1] == data_b[WIDTH-1] && sum_ab[WIDTH-1] != data_a[WIDTH-1])
                    simple_flag = data_a[WIDTH-1] ? FLAG_UNF : FLAG_OVF;
            end
            OP_SUB: begin
                simple_res = dif_ab;
                if (data_a[WIDTH-1] != data_b[WIDTH-1] && dif_ab[WIDTH-1] != data_a[WIDTH-1])
                    simple_flag = data_a[WIDTH-1] ? FLAG_UNF : FLAG_OVF;
            end
            OP_AND:  simple_res = data_a & data_b;
            OP_OR:   simple_res = data_a | data_b;
            OP_NOT:  simple_res = ~data_b;
            OP_CMP: begin
                if (data_a == data_b)
                    simple_flag = FLAG_EQ;
                else if (data_a > data_b)
                    simple_flag = FLAG_ABOVE;
                else
                    simple_flag = FLAG_BELOW;
            end
            OP_DIV: begin
                simple_res  = '1;
                simple_hi   = data_a;
                simple_flag = FLAG_EXC;
            end
            default: simple_flag = FLAG_EXC;
        endcase
    end

    musa_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clock  (clock),
        .reset  (reset),
        .start  (start_iter),
        .is_div (op == OP_DIV),
        .op_a   (data_a),
        .op_b   (data_b),
        .busy   (iter_busy),
        .done   (iter_done),
        .lo     (iter_lo),
        .hi     (iter_hi)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            result    <= '0;
            result_hi <= '0;
            flag      <= FLAG_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state <= S_MUL;
                        end else if (op == OP_DIV && data_b != '0) begin
                            state <= S_DIV;
                        end else begin
                            state     <= S_DONE;
                            result    <= simple_res;
                            result_hi <= simple_hi;
                            flag      <= simple_flag;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (iter_done || !iter_busy) begin
                        state     <= S_DONE;
                        result    <= iter_lo;
                        result_hi <= iter_hi;
                        flag      <= (state == S_MUL && iter_hi != '0) ? FLAG_OVF : FLAG_NONE;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
